// File: rtl/glyph_pixel_serializer_if.sv
// Purpose: bundles the character request, glyph ROM and pixel stream signals of the serializer.
// Latency: none, wiring only.
// Backpressure: char_vld/char_rdy on the request side, pixel_vld/pixel_rdy on the pixel side.
// Ports (serializer side = master):
//   char_vld/char_rdy, ascii[7:0], line_count[2:0] : character request
//   glyph_table_address[12:0], rom_read, rom_data[7:0] : glyph ROM access
//   pixel_vld/pixel_rdy, pixel, last_pixel             : serial pixel stream
interface glyph_pixel_serializer_if;
    logic        char_vld;
    logic        char_rdy;
    logic [7:0]  ascii;
    logic [2:0]  line_count;
    logic [12:0] glyph_table_address;
    logic        rom_read;
    logic [7:0]  rom_data;
    logic        pixel_vld;
    logic        pixel_rdy;
    logic        pixel;
    logic        last_pixel;

    modport master (
        input  char_vld, ascii, line_count, rom_data, pixel_rdy,
        output char_rdy, glyph_table_address, rom_read, pixel_vld, pixel, last_pixel
    );

    modport slave (
        output char_vld, ascii, line_count, rom_data, pixel_rdy,
        input  char_rdy, glyph_table_address, rom_read, pixel_vld, pixel, last_pixel
    );
endinterface

// File: rtl/glyph_pixel_serializer.sv
// Purpose: fetches one glyph row word from ROM per character and streams it out one pixel per beat.
// Latency: handshake C0, rom_read C1, row captured end of C1+ROM_LATENCY, first pixel the cycle after.
// Backpressure: pixel held stable while pixel_rdy=0; char_rdy only in IDLE, so requests wait upstream.
// Ports: clk_i (rising edge), rst_i (synchronous, active-high), bus (glyph_pixel_serializer_if.master).
// Parameter ROM_LATENCY (1..3): cycles from rom_read high to rom_data valid.
// Macro GLYPH_PIXEL_DOUBLE_EN: when defined, each glyph bit is emitted twice (16 pixels per row).
module glyph_pixel_serializer #(
    parameter int ROM_LATENCY = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    glyph_pixel_serializer_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHIFT} state_t;

`ifdef GLYPH_PIXEL_DOUBLE_EN
    localparam int PIX_W = 4;
`else
    localparam int PIX_W = 3;
`endif
    // Pixel counter is all-ones on the final pixel of the row.
    localparam logic [PIX_W-1:0] PIX_LAST  = '1;
    localparam logic [1:0]       WAIT_LAST = 2'(ROM_LATENCY - 1);

    state_t             state_q, state_d;
    logic [12:0]        addr_q, addr_d;
    logic [7:0]         sreg_q, sreg_d;
    logic [1:0]         wait_cnt_q, wait_cnt_d;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;

    // Two glyph rows share a ROM word, so the lowest scan line bit does not address the ROM.
    logic unused_line_lsb;
    assign unused_line_lsb = bus.line_count[0];

    assign bus.glyph_table_address = addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            sreg_q     <= '0;
            wait_cnt_q <= '0;
            pix_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sreg_q     <= sreg_d;
            wait_cnt_q <= wait_cnt_d;
            pix_cnt_q  <= pix_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        sreg_d         = sreg_q;
        wait_cnt_d     = wait_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        bus.char_rdy   = 1'b0;
        bus.rom_read   = 1'b0;
        bus.pixel_vld  = 1'b0;
        bus.pixel      = 1'b0;
        bus.last_pixel = 1'b0;

        case (state_q)
            IDLE: begin
                bus.char_rdy = 1'b1;
                if (bus.char_vld) begin
                    addr_d  = {3'b000, bus.ascii, 2'b00} + {11'b0, bus.line_count[2:1]};
                    state_d = FETCH;
                end
            end
            FETCH: begin
                bus.rom_read = 1'b1;
                wait_cnt_d   = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                // rom_data is only trusted in the last wait cycle; anything earlier is ignored.
                if (wait_cnt_q == WAIT_LAST) begin
                    sreg_d    = bus.rom_data;
                    pix_cnt_d = '0;
                    state_d   = SHIFT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            SHIFT: begin
                bus.pixel_vld  = 1'b1;
                bus.pixel      = sreg_q[7];
                bus.last_pixel = (pix_cnt_q == PIX_LAST);
                if (bus.pixel_rdy) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
`ifdef GLYPH_PIXEL_DOUBLE_EN
                    // Advance to the next glyph bit only after its second copy is taken.
                    if (pix_cnt_q[0]) begin
                        sreg_d = {sreg_q[6:0], 1'b0};
                    end
`else
                    sreg_d = {sreg_q[6:0], 1'b0};
`endif
                    if (pix_cnt_q == PIX_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_glyph_pixel_serializer.sv
// Purpose: randomized and directed check of glyph_pixel_serializer against a row-level pixel model.
// Latency: n/a (bench).
// Backpressure: drives random and directed pixel_rdy stalls.
module tb_glyph_pixel_serializer;

    localparam int LAT = 1;
`ifdef GLYPH_PIXEL_DOUBLE_EN
    localparam int REP = 2;
`else
    localparam int REP = 1;
`endif
    localparam int NPIX = 8 * REP;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    glyph_pixel_serializer_if bus();
    glyph_pixel_serializer_if bus3();

    glyph_pixel_serializer #(.ROM_LATENCY(LAT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    glyph_pixel_serializer #(.ROM_LATENCY(3)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus3)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ROM models: data valid exactly LAT cycles after the read strobe, random junk otherwise.
    logic [7:0] rom_val  = '0;
    logic [7:0] rom_val3 = '0;
    logic [3:0] rd_pipe  = '0;
    logic [3:0] rd_pipe3 = '0;

    always @(posedge clk) begin
        rd_pipe  <= {rd_pipe[2:0], bus.rom_read === 1'b1};
        rd_pipe3 <= {rd_pipe3[2:0], bus3.rom_read === 1'b1};
    end

    always @(negedge clk) begin
        bus.rom_data  = rd_pipe[LAT-1] ? rom_val  : 8'($urandom);
        bus3.rom_data = rd_pipe3[2]    ? rom_val3 : 8'($urandom);
    end

    function automatic logic [12:0] model_addr(input logic [7:0] code, input logic [2:0] line);
        return 13'(code) * 13'd4 + 13'(line / 2);
    endfunction

    function automatic logic model_pix(input logic [7:0] data, input int k);
        return data[7 - k / REP];
    endfunction

    // Runs one character starting at a negedge. bp: 0 always ready, 1 random stalls,
    // 2 three stall cycles on the 4th pixel. abort_at >= 0 resets while that pixel is shown.
    task automatic run_char(input logic [7:0] code, input logic [2:0] line, input logic [7:0] data,
                            input int bp, input int abort_at);
        logic [12:0] exp_addr;
        int          k;
        int          cyc;
        int          stall;
        logic        rdy;
        exp_addr = model_addr(code, line);
        rom_val  = data;
        bus.char_vld   = 1'b1;
        bus.ascii      = code;
        bus.line_count = line;
        cyc = 0;
        while (bus.char_rdy !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("hs_wait", 32'(cyc < 20), 1);
        @(negedge clk);
        // C1: fetch cycle; scramble inputs to prove they were sampled on the handshake.
        bus.char_vld   = 1'b0;
        bus.ascii      = 8'($urandom);
        bus.line_count = 3'($urandom);
        check("rom_read_c1", bus.rom_read, 1);
        check("addr_c1", bus.glyph_table_address, exp_addr);
        check("char_rdy_c1", bus.char_rdy, 0);
        check("pix_vld_c1", bus.pixel_vld, 0);
        for (int w = 0; w < LAT; w++) begin
            @(negedge clk);
            check("rom_read_wait", bus.rom_read, 0);
            check("pix_vld_wait", bus.pixel_vld, 0);
            check("addr_hold", bus.glyph_table_address, exp_addr);
        end
        @(negedge clk);
        k = 0;
        cyc = 0;
        stall = 0;
        while (k < NPIX && cyc < 400) begin
            check("pix_vld", bus.pixel_vld, 1);
            check("pixel", bus.pixel, model_pix(data, k));
            check("last_pixel", bus.last_pixel, 32'(k == NPIX - 1));
            check("char_rdy_busy", bus.char_rdy, 0);
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_pix_vld", bus.pixel_vld, 0);
                check("abort_char_rdy", bus.char_rdy, 1);
                check("abort_rom_read", bus.rom_read, 0);
                check("abort_addr", bus.glyph_table_address, 0);
                return;
            end
            if (bp == 1)
                rdy = ($urandom_range(0, 3) != 0);
            else if (bp == 2 && k == 3 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end else
                rdy = 1'b1;
            bus.pixel_rdy = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) k++;
        end
        bus.pixel_rdy = 1'b1;
        check("pix_timeout", 32'(k == NPIX), 1);
        check("done_char_rdy", bus.char_rdy, 1);
        check("done_pix_vld", bus.pixel_vld, 0);
        check("done_last", bus.last_pixel, 0);
        if (bp == 2) check("stall_count", stall, 3);
    endtask

    initial begin
        int cyc;
        int k;
        bus.char_vld   = 1'b0;
        bus.ascii      = '0;
        bus.line_count = '0;
        bus.pixel_rdy  = 1'b1;
        bus3.char_vld   = 1'b0;
        bus3.ascii      = '0;
        bus3.line_count = '0;
        bus3.pixel_rdy  = 1'b1;

        // Reset with a coincident request: reset must win.
        rst = 1'b1;
        bus.char_vld = 1'b1;
        bus.ascii = 8'h55;
        @(negedge clk);
        @(negedge clk);
        check("rst_char_rdy", bus.char_rdy, 1);
        check("rst_rom_read", bus.rom_read, 0);
        check("rst_pix_vld", bus.pixel_vld, 0);
        check("rst_pixel", bus.pixel, 0);
        check("rst_last", bus.last_pixel, 0);
        check("rst_addr", bus.glyph_table_address, 0);
        rst = 1'b0;
        bus.char_vld = 1'b0;
        @(negedge clk);
        check("idle_rom_read", bus.rom_read, 0);
        check("idle_char_rdy", bus.char_rdy, 1);

        // Directed rows.
        run_char(8'h41, 3'd5, 8'hA5, 0, -1);
        run_char(8'h41, 3'd5, 8'hA5, 2, -1);
        run_char(8'h81, 3'd0, 8'h81, 0, -1);
        run_char(8'h12, 3'd3, 8'h3C, 0, 4);
        run_char(8'hFF, 3'd7, 8'hFF, 0, -1);
        run_char(8'h00, 3'd1, 8'h00, 1, -1);

        // Random rows with random backpressure.
        for (int n = 0; n < 30; n++)
            run_char(8'($urandom), 3'($urandom), 8'($urandom), 1, -1);

        // Longest ROM latency instance.
        rom_val3 = 8'h96;
        bus3.char_vld   = 1'b1;
        bus3.ascii      = 8'h7F;
        bus3.line_count = 3'd7;
        @(negedge clk);
        bus3.char_vld = 1'b0;
        check("l3_rom_read_c1", bus3.rom_read, 1);
        check("l3_addr", bus3.glyph_table_address, 13'h1FF);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            check("l3_wait_pix_vld", bus3.pixel_vld, 0);
            check("l3_wait_rom_read", bus3.rom_read, 0);
        end
        @(negedge clk);
        k = 0;
        cyc = 0;
        while (k < NPIX && cyc < 40) begin
            check("l3_pix_vld", bus3.pixel_vld, 1);
            check("l3_pixel", bus3.pixel, model_pix(8'h96, k));
            check("l3_last", bus3.last_pixel, 32'(k == NPIX - 1));
            @(negedge clk);
            cyc++;
            k++;
        end
        check("l3_done_char_rdy", bus3.char_rdy, 1);
        check("l3_done_pix_vld", bus3.pixel_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
